// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC source select codes and the fetch state encoding.
// Used by the control FSM and by the fetch unit's PC mux.
package cpu_pkg;

  localparam logic [1:0] PC_S_SEQ = 2'b00;
  localparam logic [1:0] PC_S_B   = 2'b01;
  localparam logic [1:0] PC_S_F   = 2'b10;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'b00,
    FS_REQ   = 2'b01,
    FS_DRAIN = 2'b10,
    FS_DONE  = 2'b11
  } fetch_state_e;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end. Owns PC, issues word reads on the
// imem req/ack interface, latches the returned word into IR and pulses
// W_IR_valid for one cycle. Applies PC redirects from the control FSM.
//
// Ports:
//   clk, rst_n        clock / async active-low reset
//   write_ir          fetch request (sampled in IDLE)
//   write_pc, pc_s    redirect strobe and source (01 = B_data, 10 = F_data)
//   B_data, F_data    redirect targets
//   imem_rdata/ack    memory return data and one-cycle valid
//   imem_req/addr     registered read request and word address
//   IR, W_IR_valid    latched instruction and its one-cycle valid pulse
//   PC                address of the next fetch
//   busy              request outstanding (REQ or DRAIN)
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_ir,
  input  logic        write_pc,
  input  logic [1:0]  pc_s,
  input  logic [31:0] B_data,
  input  logic [31:0] F_data,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] IR,
  output logic        W_IR_valid,
  output logic [31:0] PC,
  output logic        busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic         wvld_q, wvld_d;

  // Only the B and F sources are real redirects; 00 and 11 leave PC alone.
  logic        redir;
  logic [31:0] tgt;
  assign redir = write_pc && ((pc_s == PC_S_B) || (pc_s == PC_S_F));
  assign tgt   = word_align((pc_s == PC_S_B) ? B_data : F_data);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    req_d   = req_q;
    wvld_d  = 1'b0;

    if (redir) pc_d = tgt;

    unique case (state_q)
      FS_IDLE: begin
        // A redirect this cycle would make the current PC stale; the fetch
        // starts next cycle from the new PC instead.
        if (write_ir && !redir) begin
          state_d = FS_REQ;
          req_d   = 1'b1;
          addr_d  = word_align(pc_q);
        end
      end
      FS_REQ: begin
        if (imem_ack) begin
          if (redir) begin
            // Redirect beats the returning word: drop it, maybe re-issue.
            state_d = write_ir ? FS_REQ : FS_IDLE;
            req_d   = write_ir;
            if (write_ir) addr_d = tgt;
          end else begin
            ir_d    = imem_rdata;
            pc_d    = pc_q + 32'(PC_STEP);
            req_d   = 1'b0;
            wvld_d  = 1'b1;
            state_d = FS_DONE;
          end
        end else if (redir) begin
          // Request already on the bus and can't be withdrawn.
          state_d = FS_DRAIN;
        end
      end
      FS_DRAIN: begin
        if (imem_ack) begin
          state_d = write_ir ? FS_REQ : FS_IDLE;
          req_d   = write_ir;
          if (write_ir) addr_d = word_align(pc_d);
        end
      end
      FS_DONE: state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      wvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      wvld_q  <= wvld_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign IR         = ir_q;
  assign W_IR_valid = wvld_q;
  assign PC         = pc_q;
  assign busy       = (state_q == FS_REQ) || (state_q == FS_DRAIN);

endmodule
